// File: rtl/mul_arbiter.sv
// Two-port front end for one shared multi-cycle multiplier: round-robin issue, in-order ownership tags,
// per-port result FIFOs. Define MUL_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module mul_arbiter #(
   parameter int TAG_DEPTH = 4,
   parameter int RES_DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_signed,
   input  logic [31:0] req_x0,
   input  logic [31:0] req_x1,
   input  logic [31:0] req_y0,
   input  logic [31:0] req_y1,
   output logic        mul_in_valid,
   input  logic        mul_in_ready,
   output logic [32:0] mul_src2,
   output logic [32:0] mul_src1,
   input  logic        mul_out_valid,
   input  logic [63:0] mul_result,
   output logic [1:0]  res_valid,
   input  logic [1:0]  res_ready,
   output logic [63:0] res_data0,
   output logic [63:0] res_data1,
   output logic        err
);
   localparam int TW = $clog2(TAG_DEPTH);
   localparam int CW = TW + 1;
   localparam int RW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int OW = $clog2(RES_DEPTH) + 1;

   logic                 run_q, run_d;
   logic                 err_q, err_d;
   logic                 tag_mem_q [TAG_DEPTH];
   logic [TW-1:0]        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [CW-1:0]        tag_cnt_q, tag_cnt_d;
   logic [1:0][CW-1:0]   infl_q, infl_d;
   logic [63:0]          res_mem_q [2][RES_DEPTH];
   logic [1:0][RW-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
   logic [1:0][OW-1:0]   res_occ_q, res_occ_d;
   logic [1:0]           elig, grant, res_push, res_pop;
   logic                 g, issue, done, tag_head;
   logic [31:0]          op_x, op_y;
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
   logic                 rr_q, rr_d;
`endif

   function automatic logic [RW-1:0] rnext(input logic [RW-1:0] p);
      return (p == RW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credits count both in-flight products and occupied slots, so a granted issue always has a landing slot.
   always_comb begin
      elig = '0;
      for (int i = 0; i < 2; i++)
         elig[i] = run_q & req_valid[i] & (tag_cnt_q != CW'(TAG_DEPTH)) &
                   (int'(infl_q[i]) + int'(res_occ_q[i]) < RES_DEPTH);
`ifdef MUL_ARB_FIXED_PRIO_EN
      grant = {elig[1] & ~elig[0], elig[0]};
`else
      grant = (&elig) ? (rr_q ? 2'b10 : 2'b01) : elig;
`endif
   end

   assign g            = grant[1];
   assign mul_in_valid = |grant;
   assign req_ready    = grant & {2{mul_in_ready}};
   assign issue        = mul_in_valid & mul_in_ready;
   assign op_x         = g ? req_x1 : req_x0;
   assign op_y         = g ? req_y1 : req_y0;
   assign mul_src2     = mul_in_valid ? {req_signed[g] & op_x[31], op_x} : '0;
   assign mul_src1     = mul_in_valid ? {req_signed[g] & op_y[31], op_y} : '0;
   assign done         = mul_out_valid & (tag_cnt_q != '0);
   assign tag_head     = tag_mem_q[tag_rd_q];
   assign res_data0    = res_mem_q[0][res_rd_q[0]];
   assign res_data1    = res_mem_q[1][res_rd_q[1]];
   assign err          = err_q;

   always_comb begin
      run_d     = 1'b1;
      err_d     = err_q | (mul_out_valid & ~done);
      tag_wr_d  = issue ? tag_wr_q + 1'b1 : tag_wr_q;
      tag_rd_d  = done ? tag_rd_q + 1'b1 : tag_rd_q;
      tag_cnt_d = tag_cnt_q + CW'(issue) - CW'(done);
      res_valid = '0;
      res_push  = '0;
      res_pop   = '0;
      infl_d    = infl_q;
      res_occ_d = res_occ_q;
      res_wr_d  = res_wr_q;
      res_rd_d  = res_rd_q;
      for (int i = 0; i < 2; i++) begin
         res_valid[i] = (res_occ_q[i] != '0);
         res_push[i]  = done & (tag_head == 1'(i));
         res_pop[i]   = res_valid[i] & res_ready[i];
         infl_d[i]    = infl_q[i] + CW'(issue & (g == 1'(i))) - CW'(res_push[i]);
         res_occ_d[i] = res_occ_q[i] + OW'(res_push[i]) - OW'(res_pop[i]);
         res_wr_d[i]  = res_push[i] ? rnext(res_wr_q[i]) : res_wr_q[i];
         res_rd_d[i]  = res_pop[i] ? rnext(res_rd_q[i]) : res_rd_q[i];
      end
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
      rr_d = issue ? ~g : rr_q;
`endif
   end

   // run_q keeps issue off until the first edge after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_q     <= 1'b0;
         err_q     <= 1'b0;
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         tag_cnt_q <= '0;
         infl_q    <= '0;
         res_wr_q  <= '0;
         res_rd_q  <= '0;
         res_occ_q <= '0;
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
         rr_q      <= 1'b0;
`endif
      end else begin
         run_q     <= run_d;
         err_q     <= err_d;
         tag_wr_q  <= tag_wr_d;
         tag_rd_q  <= tag_rd_d;
         tag_cnt_q <= tag_cnt_d;
         infl_q    <= infl_d;
         res_wr_q  <= res_wr_d;
         res_rd_q  <= res_rd_d;
         res_occ_q <= res_occ_d;
`ifdef MUL_ARB_FIXED_PRIO_EN
`else
         rr_q      <= rr_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (issue) tag_mem_q[tag_wr_q] <= g;
      for (int i = 0; i < 2; i++)
         if (res_push[i]) res_mem_q[i][res_wr_q[i]] <= mul_result;
   end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter; models the shared multiplier either as directed pulses or a 1-cycle auto multiplier.
module tb_mul_arbiter;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  req_valid, req_ready, req_signed, res_valid, res_ready;
   logic [31:0] req_x0, req_x1, req_y0, req_y1;
   logic        mul_in_valid, mul_in_ready, mul_out_valid, err;
   logic [32:0] mul_src2, mul_src1;
   logic [63:0] mul_result, res_data0, res_data1;
   logic        auto_en, am_v, dir_v;
   logic [63:0] am_p, dir_r;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n0, n1;

   mul_arbiter #(.TAG_DEPTH(4), .RES_DEPTH(2)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
      .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
      .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
      .mul_src2(mul_src2), .mul_src1(mul_src1),
      .mul_out_valid(mul_out_valid), .mul_result(mul_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data0(res_data0), .res_data1(res_data1), .err(err)
   );

   always #5 clk = ~clk;

   assign mul_out_valid = auto_en ? am_v : dir_v;
   assign mul_result    = auto_en ? am_p : dir_r;

   // Environment multiplier: one-cycle latency, in order.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         am_v <= 1'b0;
         am_p <= '0;
      end else begin
         am_v <= mul_in_valid & mul_in_ready;
         am_p <= {{31{mul_src2[32]}}, mul_src2} * {{31{mul_src1[32]}}, mul_src1};
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [63:0] r);
      dir_v = 1'b1;
      dir_r = r;
      tick();
      dir_v = 1'b0;
      #1;
   endtask

   initial begin
      req_valid = 2'b11; req_signed = 2'b00; res_ready = 2'b11; mul_in_ready = 1'b1;
      req_x0 = 32'd0; req_x1 = 32'd0; req_y0 = 32'd0; req_y1 = 32'd0;
      auto_en = 1'b0; dir_v = 1'b0; dir_r = '0;
      #3;
      chk("rst_res_valid", res_valid, 2'b00);
      chk("rst_in_valid", mul_in_valid, 1'b0);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_err", err, 1'b0);
      chk("rst_src2", mul_src2, 33'd0);
      chk("rst_src1", mul_src1, 33'd0);
      tick();
      resetn = 1'b1; req_valid = 2'b00;
      tick();

      // single unsigned request on port 0
      req_valid = 2'b01; req_x0 = 32'd3; req_y0 = 32'd5;
      #1;
      chk("p0_req_ready", req_ready, 2'b01);
      chk("p0_src2", mul_src2, 33'h0_00000003);
      chk("p0_src1", mul_src1, 33'h0_00000005);
      tick();
      req_valid = 2'b00;
      #1;
      chk("p0_in_valid_idle", mul_in_valid, 1'b0);
      pulse(64'd15);
      chk("p0_res_valid", res_valid, 2'b01);
      chk("p0_res_data", res_data0, 64'd15);
      tick(); #1;
      chk("p0_res_drained", res_valid, 2'b00);

      // sign handling on port 1
      req_valid = 2'b10; req_signed = 2'b10; req_x1 = 32'hFFFF_FFFF; req_y1 = 32'd2;
      #1;
      chk("s1_req_ready", req_ready, 2'b10);
      chk("s1_src2", mul_src2, 33'h1_FFFFFFFF);
      chk("s1_src1", mul_src1, 33'h0_00000002);
      tick();
      req_valid = 2'b00;
      pulse(64'hFFFF_FFFF_FFFF_FFFE);
      chk("s1_res_valid", res_valid, 2'b10);
      chk("s1_res_data", res_data1, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      req_valid = 2'b10; req_signed = 2'b00;
      #1;
      chk("u1_src2", mul_src2, 33'h0_FFFFFFFF);
      tick();
      req_valid = 2'b00;
      pulse(64'h0000_0001_FFFF_FFFE);
      chk("u1_res_valid", res_valid, 2'b10);
      chk("u1_res_data", res_data1, 64'h0000_0001_FFFF_FFFE);
      tick(); #1;
      chk("u1_res_drained", res_valid, 2'b00);

      // contention: both ports every cycle
      auto_en = 1'b1;
      req_x0 = 32'd2; req_y0 = 32'd3; req_x1 = 32'd4; req_y1 = 32'd5;
      req_valid = 2'b11;
      for (int c = 0; c < 8; c++) begin
         #1;
`ifdef MUL_ARB_FIXED_PRIO_EN
         if (c < 2) chk("fp_grant", req_ready, 2'b01);
`else
         chk("rr_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_res_valid", res_valid, (c < 2) ? 2'b00 : (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c >= 2) chk("rr_res_data", (c % 2 == 0) ? res_data0 : res_data1,
                         (c % 2 == 0) ? 64'd6 : 64'd20);
`endif
         tick();
      end
      req_valid = 2'b00;
      repeat (3) tick();
      #1;
      chk("rr_drained", res_valid, 2'b00);

      // backpressure on port 0
      res_ready = 2'b10; req_x0 = 32'd7; req_y0 = 32'd6; req_x1 = 32'd1; req_y1 = 32'd1;
      req_valid = 2'b01; n0 = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (req_ready[0]) n0++;
         tick();
      end
      chk("bp_p0_issues", n0, 2);
      req_valid = 2'b11; n0 = 0; n1 = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (req_ready[0]) n0++;
         if (req_ready[1]) n1++;
         tick();
      end
      chk("bp_p0_blocked", n0, 0);
      chk("bp_p1_flows", (n1 > 0), 1'b1);
      #1;
      chk("bp_p0_valid", res_valid[0], 1'b1);
      chk("bp_p0_data", res_data0, 64'd42);
      res_ready = 2'b11;
      tick();
      res_ready = 2'b10; n0 = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (req_ready[0]) n0++;
         tick();
      end
      chk("bp_p0_one_more", n0, 1);
      chk("bp_p0_head", res_data0, 64'd42);
      req_valid = 2'b00; res_ready = 2'b11;
      repeat (6) tick();
      #1;
      chk("bp_drained", res_valid, 2'b00);
      auto_en = 1'b0;

      // spurious completion
      pulse(64'd123);
      chk("err_set", err, 1'b1);
      chk("err_no_result", res_valid, 2'b00);
      tick(); #1;
      chk("err_sticky", err, 1'b1);

      // reset with three in flight
      req_x0 = 32'd2; req_y0 = 32'd3; req_x1 = 32'd4; req_y1 = 32'd5;
      req_valid = 2'b11;
      repeat (3) tick();
      resetn = 1'b0;
      #1;
      chk("mid_rst_in_valid", mul_in_valid, 1'b0);
      chk("mid_rst_req_ready", req_ready, 2'b00);
      chk("mid_rst_res_valid", res_valid, 2'b00);
      chk("mid_rst_err", err, 1'b0);
      tick();
      resetn = 1'b1;
      #1;
      chk("post_rst_idle", mul_in_valid, 1'b0);
      tick();

      // tag FIFO fills after four issues
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("tf_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
         tick();
      end
      #1;
      chk("tf_full", req_ready, 2'b00);
      tick(); #1;
      chk("tf_full_hold", req_ready, 2'b00);
      pulse(64'd6);
      chk("tf_res_valid", res_valid, 2'b01);
      chk("tf_res_data", res_data0, 64'd6);
      chk("tf_credit_wait", req_ready, 2'b00);
      tick(); #1;
      chk("tf_reissue", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      for (int k = 0; k < 4; k++) begin
         pulse((k % 2 == 0) ? 64'd20 : 64'd6);
         chk("tf_drain_valid", res_valid, (k % 2 == 0) ? 2'b10 : 2'b01);
         chk("tf_drain_data", (k % 2 == 0) ? res_data1 : res_data0,
             (k % 2 == 0) ? 64'd20 : 64'd6);
      end
      tick(); #1;
      chk("final_res_valid", res_valid, 2'b00);
      chk("final_err", err, 1'b0);
      chk("final_in_valid", mul_in_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
